// File: rtl/panel_io_pkg.sv
// Shared constants and helpers for the DE1-SoC front-panel register window.
package panel_io_pkg;

  localparam logic [2:0] ADDR_KEYS  = 3'd0;
  localparam logic [2:0] ADDR_SW    = 3'd1;
  localparam logic [2:0] ADDR_EDGE  = 3'd2;
  localparam logic [2:0] ADDR_MASK  = 3'd3;
  localparam logic [2:0] ADDR_MODE  = 3'd4;
  localparam logic [2:0] ADDR_HEXLO = 3'd5;
  localparam logic [2:0] ADDR_HEXHI = 3'd6;
  localparam logic [2:0] ADDR_BLINK = 3'd7;

  // Active-high glyph, bit0 = segment a.
  function automatic logic [6:0] hex7(input logic [3:0] nibble);
    case (nibble)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      4'hF:    hex7 = 7'h71;
      default: hex7 = 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/panel_io_avalon_debounce.sv
// Per-bit 2-FF synchroniser followed by a stability counter; output moves only
// after CYCLES consecutive cycles of disagreement with the synchronised input.
module panel_debounce #(
  parameter int WIDTH  = 4,
  parameter int CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;
  logic [WIDTH-1:0] deb_r;
  logic [CW-1:0]    cnt_r [WIDTH];

  // Two-stage synchroniser for the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
    end
  end

  // Stability counter per bit; any agreement restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_r <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_r[i] == deb_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_MAX) begin
          deb_r[i] <= sync_r[i];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + 1'b1;
        end
      end
    end
  end

  assign dout = deb_r;

endmodule

// File: rtl/panel_io_avalon.sv
// Avalon-MM front-panel slave: debounced KEY/SW, key press capture with IRQ, HEX drive.
// Optional digit blinking is compiled in when PANEL_BLINK_EN is defined.
module panel_io_avalon
  import panel_io_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter int NUM_SW       = 10,
  parameter int NUM_HEX      = 6,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int BLINK_DIV    = 12500000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 irq,
  input  logic [NUM_KEYS-1:0]  key_n_in,
  input  logic [NUM_SW-1:0]    sw_in,
  output logic [7*NUM_HEX-1:0] hex_n_out
);

  logic [NUM_KEYS-1:0]  key_deb_s;
  logic [NUM_SW-1:0]    sw_deb_s;
  logic [NUM_KEYS-1:0]  key_prev_r;
  logic [NUM_KEYS-1:0]  edge_r;
  logic [NUM_KEYS-1:0]  edge_next_s;
  logic [NUM_KEYS-1:0]  mask_r;
  logic [NUM_HEX-1:0]   mode_r;
  logic [NUM_HEX-1:0]   blank_s;
  logic [7:0]           hex_r [NUM_HEX];
  logic [6:0]           glyph_s [NUM_HEX];
  logic [63:0]          hex_all_s;
  logic [31:0]          rd_mux_s;
  logic [31:0]          readdata_r;
  logic                 irq_r;
  logic [7*NUM_HEX-1:0] seg_n_s;
  logic [7*NUM_HEX-1:0] hex_n_r;

  panel_debounce #(.WIDTH(NUM_KEYS), .CYCLES(DEBOUNCE_CYC)) u_key_deb (
    .clk(clk), .reset_n(reset_n), .din(~key_n_in), .dout(key_deb_s)
  );

  panel_debounce #(.WIDTH(NUM_SW), .CYCLES(DEBOUNCE_CYC)) u_sw_deb (
    .clk(clk), .reset_n(reset_n), .din(sw_in), .dout(sw_deb_s)
  );

  // Press capture: a new press sets the bit even if software clears it this cycle.
  always_comb begin
    edge_next_s = edge_r;
    if (avs_write && (avs_address == ADDR_EDGE)) begin
      edge_next_s = edge_r & ~avs_writedata[NUM_KEYS-1:0];
    end else begin
      edge_next_s = edge_r;
    end
    edge_next_s = edge_next_s | (key_deb_s & ~key_prev_r);
  end

  // Control/status registers, edge capture and interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_prev_r <= '0;
      edge_r     <= '0;
      mask_r     <= '0;
      mode_r     <= '0;
      irq_r      <= 1'b0;
      for (int d = 0; d < NUM_HEX; d++) hex_r[d] <= '0;
    end else begin
      key_prev_r <= key_deb_s;
      edge_r     <= edge_next_s;
      irq_r      <= |(edge_r & mask_r);
      if (avs_write) begin
        case (avs_address)
          ADDR_MASK: mask_r <= avs_writedata[NUM_KEYS-1:0];
          ADDR_MODE: mode_r <= avs_writedata[NUM_HEX-1:0];
          default:   ;
        endcase
      end
      for (int d = 0; d < NUM_HEX; d++) begin
        if (avs_write && (avs_address == ((d < 4) ? ADDR_HEXLO : ADDR_HEXHI))) begin
          hex_r[d] <= avs_writedata[8*(d%4) +: 8];
        end
      end
    end
  end

`ifdef PANEL_BLINK_EN
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BCW-1:0] BLINK_MAX = BCW'(BLINK_DIV - 1);

  logic [NUM_HEX-1:0] blink_r;
  logic [BCW-1:0]     blink_cnt_r;
  logic               blink_off_r;

  // Blink register and free-running phase generator; phase starts "on".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_r     <= '0;
      blink_cnt_r <= '0;
      blink_off_r <= 1'b0;
    end else begin
      if (avs_write && (avs_address == ADDR_BLINK)) blink_r <= avs_writedata[NUM_HEX-1:0];
      if (blink_cnt_r == BLINK_MAX) begin
        blink_cnt_r <= '0;
        blink_off_r <= ~blink_off_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + 1'b1;
      end
    end
  end

  // Digits selected for blinking go dark during the off phase.
  always_comb begin
    if (blink_off_r) begin
      blank_s = blink_r;
    end else begin
      blank_s = '0;
    end
  end
`else
  assign blank_s = '0;
`endif

  // Readback image of the digit bytes; absent digits read as zero.
  always_comb begin
    hex_all_s = '0;
    for (int d = 0; d < NUM_HEX; d++) hex_all_s[8*d +: 8] = hex_r[d];
  end

  // Read mux, sampled with pre-write register contents.
  always_comb begin
    rd_mux_s = '0;
    case (avs_address)
      ADDR_KEYS:  rd_mux_s = 32'(key_deb_s);
      ADDR_SW:    rd_mux_s = 32'(sw_deb_s);
      ADDR_EDGE:  rd_mux_s = 32'(edge_r);
      ADDR_MASK:  rd_mux_s = 32'(mask_r);
      ADDR_MODE:  rd_mux_s = 32'(mode_r);
      ADDR_HEXLO: rd_mux_s = hex_all_s[31:0];
      ADDR_HEXHI: rd_mux_s = hex_all_s[63:32];
`ifdef PANEL_BLINK_EN
      ADDR_BLINK: rd_mux_s = 32'(blink_r);
`endif
      default:    rd_mux_s = '0;
    endcase
  end

  // Segment generation: decoded glyph or raw bits, then inverted for the pins.
  always_comb begin
    seg_n_s = '1;
    for (int d = 0; d < NUM_HEX; d++) begin
      if (mode_r[d]) begin
        glyph_s[d] = hex7(hex_r[d][3:0]);
      end else begin
        glyph_s[d] = hex_r[d][6:0];
      end
      if (blank_s[d]) begin
        seg_n_s[7*d +: 7] = 7'h7F;
      end else begin
        seg_n_s[7*d +: 7] = ~glyph_s[d];
      end
    end
  end

  // Registered bus and pin outputs; readdata holds until the next read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= '0;
      hex_n_r    <= '1;
    end else begin
      if (avs_read) readdata_r <= rd_mux_s;
      hex_n_r <= seg_n_s;
    end
  end

  assign avs_readdata = readdata_r;
  assign irq          = irq_r;
  assign hex_n_out    = hex_n_r;

endmodule
